// File: rtl/subtractor_rr_arbiter.sv
// -----------------------------------------------------------------------------
// subtractor_rr_arbiter
//
// Shares one WIDTH-bit borrow-chain subtractor between NREQ requesters.
// A round-robin arbiter picks one requester in IDLE, its operands are
// registered, the difference is computed in EXEC and the result is held on a
// single response channel (tagged with the requester id) in RESP until the
// consumer takes it. Only one transaction is ever in flight.
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holds valid and its payload
// stable until that edge; ready never depends on a transfer having happened.
//
// Optional build macro: SUB_SATURATE_EN
//   defined   : when the borrow is 1, resp_d is clamped to 0 (resp_bout stays 1)
//   undefined : resp_d is the modulo-2^WIDTH difference
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   [NREQ]        per-requester operand valid
//   req_ready    out  [NREQ]        per-requester accept, one-hot or zero
//   req_a        in   [NREQ*WIDTH]  minuends, requester i at [i*WIDTH +: WIDTH]
//   req_b        in   [NREQ*WIDTH]  subtrahends, same packing
//   resp_valid   out               result valid
//   resp_ready   in                consumer accepts result
//   resp_id      out  [IDW]        requester that owns the result
//   resp_d       out  [WIDTH]      A - B
//   resp_bout    out               borrow out, 1 iff A < B (unsigned)
//   dbg_state_o  out  [2]          current FSM state (IDLE=0, EXEC=1, RESP=2)
//   dbg_rr_ptr_o out  [IDW]        last requester whose response completed
// -----------------------------------------------------------------------------
module subtractor_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_d,
    output logic                  resp_bout,
    output logic [1:0]            dbg_state_o,
    output logic [IDW-1:0]        dbg_rr_ptr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [IDW-1:0]     id_q;
    logic               resp_valid_q;
    logic [IDW-1:0]     resp_id_q;
    logic [WIDTH-1:0]   resp_d_q;
    logic               resp_bout_q;

    logic               grant_found;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     cand;

    logic [WIDTH-1:0]   a_arr [NREQ];
    logic [WIDTH-1:0]   b_arr [NREQ];

    logic [WIDTH:0]     borrow;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   d_result;

    // Unpack the flat operand buses into per-requester words.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    // Round-robin search: start one past the last completed requester and
    // wrap, so the most recently served requester has the lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Ripple borrow chain: d_i = a_i ^ b_i ^ bin_i,
    // bout_i = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i).
    always_comb begin
        borrow    = '0;
        diff      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i]       = a_q[i] ^ b_q[i] ^ borrow[i];
            borrow[i+1]   = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & borrow[i]);
        end
    end

`ifdef SUB_SATURATE_EN
    // Clamp underflow to zero; the borrow flag still tells the consumer.
    assign d_result = borrow[WIDTH] ? '0 : diff;
`else
    assign d_result = diff;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accept is combinational and only offered while idle.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_d_q     <= '0;
            resp_bout_q  <= 1'b0;
            rr_ptr_q     <= IDW'(NREQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        a_q  <= a_arr[grant_id];
                        b_q  <= b_arr[grant_id];
                        id_q <= grant_id;
                    end
                end
                EXEC: begin
                    resp_d_q     <= d_result;
                    resp_bout_q  <= borrow[WIDTH];
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    // Pointer moves on completion only, so a discarded
                    // transaction never affects priority.
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rr_ptr_q     <= resp_id_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_d       = resp_d_q;
    assign resp_bout    = resp_bout_q;
    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;

endmodule
